// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
//
// Sequencer between a MIPS-style HI/LO request port and an external iterative
// multiply/divide unit. A request is accepted only in IDLE. MULT/MULTU/DIV/DIVU
// launch the unit and wait for its completion pulse, guarded by a watchdog.
// MFHI/MFLO read HI or LO back. MTHI/MTLO write HI or LO directly.
//
// Encodings used on the unit interface:
//   MD_MorD : 0 = multiply, 1 = divide
//   MD_SorU : 1 = signed,   0 = unsigned
//   MD_HorL : 1 = HI,       0 = LO
//
// Ports
//   Clk, Reset      : clock; synchronous active-low reset
//   Req_Valid/Op    : request strobe and opcode (0 MULT .. 7 MTLO)
//   Req_RS, Req_RT  : operands (RS = dividend/multiplicand and MT source)
//   Req_Ready       : request accepted this cycle (IDLE only)
//   Stall           : Req_Valid held off because the controller is occupied
//   Res_Valid/Data  : one-cycle MFHI/MFLO result; data holds until next read
//   Busy, Err       : not-IDLE indicator; sticky watchdog timeout flag
//   MD_*            : operands, controls, completion and HI/LO data of the unit
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int WD_LIMIT = 63
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_Valid,
    input  logic [2:0]  Req_Op,
    input  logic [31:0] Req_RS,
    input  logic [31:0] Req_RT,
    output logic        Req_Ready,
    output logic        Stall,
    output logic        Res_Valid,
    output logic [31:0] Res_Data,
    output logic        Busy,
    output logic        Err,
    output logic [31:0] MD_DA,
    output logic [31:0] MD_DB,
    output logic        MD_Start,
    output logic        MD_MorD,
    output logic        MD_SorU,
    output logic        MD_HorL,
    output logic        MD_MulWrite,
    input  logic        MD_Ready,
    input  logic [31:0] MD_DC
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    localparam int          WD_W    = $clog2(WD_LIMIT + 1);
    // Value of the watchdog during the last BUSY cycle that is still allowed.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    state_e            state_q;
    logic [WD_W-1:0]   wd_q;
    logic              err_q;
    logic              res_valid_q;
    logic [31:0]       res_data_q;
    logic [31:0]       da_q;
    logic [31:0]       db_q;
    logic              mord_q;
    logic              soru_q;
    logic              horl_q;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            wd_q        <= '0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            da_q        <= '0;
            db_q        <= '0;
            mord_q      <= 1'b0;
            soru_q      <= 1'b0;
            horl_q      <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Req_Valid) begin
                        case (Req_Op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                da_q    <= Req_RS;
                                db_q    <= Req_RT;
                                mord_q  <= Req_Op[1];   // ops 2-3 divide
                                soru_q  <= ~Req_Op[0];  // even ops are signed
                                wd_q    <= '0;
                                state_q <= ST_BUSY;
                            end
                            OP_MFHI, OP_MFLO: begin
                                horl_q  <= ~Req_Op[0];  // MFHI is the even code
                                state_q <= ST_READ;
                            end
                            OP_MTHI, OP_MTLO: begin
                                da_q    <= Req_RS;
                                horl_q  <= ~Req_Op[0];  // MTHI is the even code
                                state_q <= ST_WRITE;
                            end
                            default: state_q <= ST_IDLE;
                        endcase
                    end
                end
                ST_BUSY: begin
                    wd_q <= wd_q + 1'b1;
                    if (MD_Ready) begin
                        state_q <= ST_IDLE;
                    end else if (wd_q == WD_LAST) begin
                        // Unit never answered: abandon the operation.
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    res_data_q  <= MD_DC;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                ST_WRITE: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Start is masked by Ready so the unit does not see a fresh start in the
    // cycle it completes and relaunch itself.
    assign MD_Start    = (state_q == ST_BUSY) & ~MD_Ready;
    assign MD_MulWrite = (state_q == ST_WRITE);

    assign Req_Ready   = (state_q == ST_IDLE);
    assign Stall       = Req_Valid & ~Req_Ready;
    assign Busy        = (state_q != ST_IDLE);
    assign Err         = err_q;
    assign Res_Valid   = res_valid_q;
    assign Res_Data    = res_data_q;
    assign MD_DA       = da_q;
    assign MD_DB       = db_q;
    assign MD_MorD     = mord_q;
    assign MD_SorU     = soru_q;
    assign MD_HorL     = horl_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
//
// Drives muldiv_ctrl against a cycle-level model of the multiply/divide unit
// (35-cycle multiply, 36-cycle divide from the accept cycle, optional hang) and
// checks results against an architectural HI/LO model updated per request.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Req_Valid = 1'b0;
    logic [2:0]  Req_Op = 3'd0;
    logic [31:0] Req_RS = '0;
    logic [31:0] Req_RT = '0;
    logic        Req_Ready, Stall, Res_Valid, Busy, Err;
    logic [31:0] Res_Data, MD_DA, MD_DB, MD_DC;
    logic        MD_Start, MD_MorD, MD_SorU, MD_HorL, MD_MulWrite, MD_Ready;

    muldiv_ctrl #(.WD_LIMIT(63)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req_Valid(Req_Valid), .Req_Op(Req_Op), .Req_RS(Req_RS), .Req_RT(Req_RT),
        .Req_Ready(Req_Ready), .Stall(Stall),
        .Res_Valid(Res_Valid), .Res_Data(Res_Data),
        .Busy(Busy), .Err(Err),
        .MD_DA(MD_DA), .MD_DB(MD_DB), .MD_Start(MD_Start), .MD_MorD(MD_MorD),
        .MD_SorU(MD_SorU), .MD_HorL(MD_HorL), .MD_MulWrite(MD_MulWrite),
        .MD_Ready(MD_Ready), .MD_DC(MD_DC)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // HI/LO result of a multiply/divide: {hi, lo}.
    function automatic logic [63:0] md_calc(input logic div, input logic sgn,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     qa, qb;
        logic [63:0] r;
        r = '0;
        if (!div) begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                r  = 64'(sa * sb);
            end else begin
                r = {32'b0, a} * {32'b0, b};
            end
        end else if (b != 0) begin
            if (sgn) begin
                qa = $signed(a);
                qb = $signed(b);
                r  = {32'(qa % qb), 32'(qa / qb)};
            end else begin
                r = {a % b, a / b};
            end
        end
        return r;
    endfunction

    // ---------------- multiply/divide unit model ----------------
    logic        u_run = 1'b0;
    logic        u_div = 1'b0;
    logic        u_sgn = 1'b0;
    logic        u_never = 1'b0;
    int          u_k = 0;
    logic [31:0] u_a = '0, u_b = '0, u_hi = '0, u_lo = '0;

    // First Start cycle is t+1; Ready lands at t+35 (mul) / t+36 (div).
    assign MD_Ready = u_run && !u_never && (u_k == (u_div ? 35 : 34));
    assign MD_DC    = MD_HorL ? u_hi : u_lo;

    always @(posedge Clk) begin
        if (MD_MulWrite) begin
            if (MD_HorL) u_hi <= MD_DA;
            else         u_lo <= MD_DA;
        end
        if (u_run) begin
            if (MD_Ready) begin
                {u_hi, u_lo} <= md_calc(u_div, u_sgn, u_a, u_b);
                u_run <= 1'b0;
            end else if (!MD_Start) begin
                u_run <= 1'b0;
            end else begin
                u_k <= u_k + 1;
            end
        end else if (MD_Start) begin
            u_run <= 1'b1;
            u_k   <= 1;
            u_div <= MD_MorD;
            u_sgn <= MD_SorU;
            u_a   <= MD_DA;
            u_b   <= MD_DB;
        end
    end

    int mw_cnt = 0;
    int excl_viol = 0;
    always @(posedge Clk) if (MD_MulWrite) mw_cnt <= mw_cnt + 1;
    always @(negedge Clk) if (MD_MulWrite && MD_Start) excl_viol <= excl_viol + 1;

    // ---------------- architectural reference ----------------
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    task automatic ref_apply(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        if (op <= OP_DIVU)     {ref_hi, ref_lo} = md_calc(op[1], !op[0], rs, rt);
        else if (op == OP_MTHI) ref_hi = rs;
        else if (op == OP_MTLO) ref_lo = rs;
    endtask

    // Present a request at the current negedge; returns at the negedge after accept.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         output int t_acc, output int n_stall);
        logic stall_ok;
        Req_Valid = 1'b1; Req_Op = op; Req_RS = rs; Req_RT = rt;
        n_stall = 0;
        stall_ok = 1'b1;
        while (!Req_Ready && n_stall < 200) begin
            stall_ok &= Stall;
            n_stall++;
            @(negedge Clk);
        end
        if (n_stall > 0) check_eq("stall_while_occupied", stall_ok, 1'b1);
        if (!Req_Ready)  check_eq("accept_timeout", Req_Ready, 1'b1);
        check_eq("stall_at_accept", Stall, 1'b0);
        t_acc = cyc;
        @(posedge Clk);
        @(negedge Clk);
        Req_Valid = 1'b0;
    endtask

    // Wait (bounded) for Busy to drop; verifies operand stability and Start/Ready.
    task automatic wait_idle(input logic [31:0] rs, input logic [31:0] rt,
                             output int t_idle, output int t_rdy, output logic ok);
        int n;
        n = 0; ok = 1'b1; t_rdy = -1;
        while (Busy && n < 200) begin
            ok &= (MD_DA == rs) && (MD_DB == rt) && (MD_Start == !MD_Ready) && !Req_Ready;
            if (MD_Ready && t_rdy < 0) t_rdy = cyc;
            n++;
            @(negedge Clk);
        end
        if (Busy) check_eq("idle_timeout", Busy, 1'b0);
        t_idle = cyc;
    endtask

    // Called at the negedge after an MF accept (t+1).
    task automatic check_read(input logic [31:0] exp);
        logic [31:0] held;
        check_eq("res_valid_t1", Res_Valid, 1'b0);
        @(negedge Clk);
        check_eq("res_valid_t2", Res_Valid, 1'b1);
        check_eq("res_data", Res_Data, exp);
        held = Res_Data;
        @(negedge Clk);
        check_eq("res_valid_t3", Res_Valid, 1'b0);
        check_eq("res_data_hold", Res_Data, held);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        int t, ns, ti, tr, mw0;
        logic ok;
        mw0 = mw_cnt;
        issue(op, rs, rt, t, ns);
        ref_apply(op, rs, rt);
        if (op <= OP_DIVU) begin
            wait_idle(rs, rt, ti, tr, ok);
            check_eq("md_ready_cycle", 64'(tr - t), op[1] ? 64'd36 : 64'd35);
            check_eq("idle_cycle", 64'(ti - t), op[1] ? 64'd37 : 64'd36);
            check_eq("busy_operands_start", ok, 1'b1);
        end else if (op <= OP_MFLO) begin
            check_read(op == OP_MFHI ? ref_hi : ref_lo);
        end else begin
            check_eq("mulwrite_t1", MD_MulWrite, 1'b1);
            check_eq("mulwrite_hl", MD_HorL, op == OP_MTHI);
            @(negedge Clk);
            check_eq("mulwrite_pulses", 64'(mw_cnt - mw0), 64'd1);
        end
        $display("op=%0d rs=%08h rt=%08h accepted@%0d stalls=%0d ref_hi=%08h ref_lo=%08h",
                 op, rs, rt, t, ns, ref_hi, ref_lo);
    endtask

    initial begin
        int t, ns, ti, tr, mw0;
        logic ok;
        logic [2:0] op;
        logic [31:0] rs, rt;

        // Reset state
        repeat (3) @(negedge Clk);
        check_eq("rst_busy", Busy, 1'b0);
        check_eq("rst_ready", Req_Ready, 1'b1);
        check_eq("rst_outs", {Res_Valid, Err, MD_Start, MD_MulWrite, MD_MorD, MD_SorU, MD_HorL}, 7'b0);
        check_eq("rst_data", {Res_Data, MD_DA}, 64'd0);
        check_eq("rst_db", MD_DB, 32'd0);
        Reset = 1'b1;
        @(negedge Clk);

        // Idle with no request: nothing moves
        repeat (3) @(negedge Clk);
        check_eq("idle_quiet", {Busy, Res_Valid, MD_Start, MD_MulWrite}, 4'b0);

        // MULT 7 * -3, then MFLO / MFHI
        run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD);
        run_op(OP_MFLO, '0, '0);
        check_eq("mult_lo_const", Res_Data, 32'hFFFF_FFEB);
        run_op(OP_MFHI, '0, '0);
        check_eq("mult_hi_const", Res_Data, 32'hFFFF_FFFF);

        // DIVU 100 / 7
        run_op(OP_DIVU, 32'd100, 32'd7);
        run_op(OP_MFLO, '0, '0);
        check_eq("divu_q_const", Res_Data, 32'd14);
        run_op(OP_MFHI, '0, '0);
        check_eq("divu_r_const", Res_Data, 32'd2);

        // MTHI immediately followed by MFHI
        mw0 = mw_cnt;
        run_op(OP_MTHI, 32'hDEAD_BEEF, '0);
        run_op(OP_MFHI, '0, '0);
        check_eq("mthi_mfhi_const", Res_Data, 32'hDEAD_BEEF);
        check_eq("mthi_single_pulse", 64'(mw_cnt - mw0), 64'd1);

        // MFLO presented one cycle after a MULT accept
        issue(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, t, ns);
        ref_apply(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
        check_eq("busy_after_mult", Busy, 1'b1);
        issue(OP_MFLO, '0, '0, t, ns);
        check_eq("mflo_stall_cycles", 64'(ns), 64'd35);
        check_read(ref_lo);
        $display("stalled MFLO: stalls=%0d data=%08h", ns, Res_Data);

        // Unit that never answers -> watchdog
        u_never = 1'b1;
        issue(OP_MULTU, 32'd3, 32'd5, t, ns);
        wait_idle(32'd3, 32'd5, ti, tr, ok);
        check_eq("wd_idle_cycle", 64'(ti - t), 64'd64);
        check_eq("wd_err", Err, 1'b1);
        check_eq("wd_start_low", MD_Start, 1'b0);
        check_eq("wd_ready", Req_Ready, 1'b1);
        $display("watchdog: accepted@%0d idle@%0d err=%0b", t, ti, Err);
        u_never = 1'b0;
        run_op(OP_MTLO, 32'h0BAD_F00D, '0);
        run_op(OP_MFLO, '0, '0);
        check_eq("err_sticky", Err, 1'b1);

        // Reset during a DIV
        issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, t, ns);
        while (cyc < t + 10) @(negedge Clk);
        check_eq("div_start_before_rst", MD_Start, 1'b1);
        Reset = 1'b0;
        @(negedge Clk);
        check_eq("rst2_busy_ready", {Busy, Req_Ready}, 2'b01);
        check_eq("rst2_ctl", {MD_Start, MD_MulWrite, Res_Valid, Err, MD_MorD, MD_SorU, MD_HorL}, 7'b0);
        check_eq("rst2_data", {Res_Data, MD_DA}, 64'd0);
        check_eq("rst2_db", MD_DB, 32'd0);
        Reset = 1'b1;
        $display("reset during DIV at cycle %0d", t + 10);
        run_op(OP_MULT, 32'hFFFF_FFF6, 32'd9);
        run_op(OP_MFLO, '0, '0);
        run_op(OP_MFHI, '0, '0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            rs = $urandom;
            rt = $urandom;
            if (op == OP_DIV || op == OP_DIVU) begin
                if (rt == 0) rt = 32'd1;
                if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) rt = 32'd3;
            end
            run_op(op, rs, rt);
        end
        run_op(OP_MFHI, '0, '0);
        run_op(OP_MFLO, '0, '0);

        check_eq("start_mulwrite_exclusive", 64'(excl_viol), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d, required finish earlier", cyc);
        $fatal(1, "timeout");
    end

endmodule
